// File: rtl/rs_alu_lane_if.sv
// rtl/rs_alu_lane_if.sv - allocate/mark/result bundle for the RS ALU lane
interface rs_alu_lane_if #(
  parameter int DATA_W   = 8,
  parameter int RS_DEPTH = 4
);
  localparam int IDX_W = $clog2(RS_DEPTH);

  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_opcode;
  logic [DATA_W-1:0] in_a;
  logic [DATA_W-1:0] in_b;
  logic [IDX_W-1:0]  in_idx;
  logic              mark_valid;
  logic [IDX_W-1:0]  mark_idx;
  logic              flush;
  logic              out_valid;
  logic [DATA_W:0]   out_result;
  logic [IDX_W-1:0]  out_idx;
  logic [IDX_W:0]    occupancy;
  logic              full;
  logic              empty;

  modport master (
    output in_valid, in_opcode, in_a, in_b, mark_valid, mark_idx, flush,
    input  in_ready, in_idx, out_valid, out_result, out_idx, occupancy, full, empty
  );

  modport slave (
    input  in_valid, in_opcode, in_a, in_b, mark_valid, mark_idx, flush,
    output in_ready, in_idx, out_valid, out_result, out_idx, occupancy, full, empty
  );
endinterface

// File: rtl/rs_alu_lane.sv
// rtl/rs_alu_lane.sv - circular reservation station feeding an in-order ALU
module rs_alu_lane #(
  parameter  int DATA_W   = 8,
  parameter  int RS_DEPTH = 4,
  localparam int IDX_W    = $clog2(RS_DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  rs_alu_lane_if.slave     bus
);
  localparam logic [IDX_W:0] DEPTH_L = (IDX_W+1)'(RS_DEPTH);

  logic [RS_DEPTH-1:0] e_valid, e_ready;
  logic [RS_DEPTH-1:0] v_nxt, r_nxt;
  logic [2:0]          e_op [RS_DEPTH];
  logic [DATA_W-1:0]   e_a  [RS_DEPTH];
  logic [DATA_W-1:0]   e_b  [RS_DEPTH];

  logic [IDX_W-1:0]    head, tail;
  logic [IDX_W:0]      occ;
  logic                out_valid_q;
  logic [DATA_W:0]     out_result_q;
  logic [IDX_W-1:0]    out_idx_q;

  logic                full, alloc, retire, mark_ok;
  logic [2:0]          h_op;
  logic [DATA_W-1:0]   h_a, h_b, sh;
  logic [DATA_W:0]     alu;

  assign full    = (occ == DEPTH_L);
  assign alloc   = bus.in_valid && !full;
  assign retire  = e_valid[head] && e_ready[head];
  // The allocating slot is invalid before the edge, so a same-cycle mark on it falls out here.
  assign mark_ok = bus.mark_valid && e_valid[bus.mark_idx];

  assign bus.in_ready   = !full;
  assign bus.in_idx     = tail;
  assign bus.full       = full;
  assign bus.empty      = (occ == '0);
  assign bus.occupancy  = occ;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_result = out_result_q;
  assign bus.out_idx    = out_idx_q;

  always_comb begin
    h_op = e_op[head];
    h_a  = e_a[head];
    h_b  = e_b[head];
    sh   = DATA_W'(h_b % DATA_W);
    alu  = '0;
    case (h_op)
      3'b000:  alu = {1'b0, h_a} + {1'b0, h_b};
      3'b001:  alu = {1'b0, h_a} - {1'b0, h_b};
      3'b010:  alu = {1'b0, h_a | h_b};
      3'b011:  alu = {1'b0, h_a & h_b};
      3'b100:  alu = {1'b0, h_a ^ h_b};
      3'b101:  alu = {1'b0, h_a << sh};
      3'b110:  alu = {1'b0, h_a >> sh};
      default: alu = {{DATA_W{1'b0}}, (h_a < h_b)};
    endcase
  end

  always_comb begin
    v_nxt = e_valid;
    r_nxt = e_ready;
    if (mark_ok) r_nxt[bus.mark_idx] = 1'b1;
    if (retire) begin
      v_nxt[head] = 1'b0;
      r_nxt[head] = 1'b0;
    end
    if (alloc) begin
      v_nxt[tail] = 1'b1;
      r_nxt[tail] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e_valid      <= '0;
      e_ready      <= '0;
      head         <= '0;
      tail         <= '0;
      occ          <= '0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_idx_q    <= '0;
    end else if (bus.flush) begin
      e_valid     <= '0;
      e_ready     <= '0;
      head        <= '0;
      tail        <= '0;
      occ         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      e_valid     <= v_nxt;
      e_ready     <= r_nxt;
      out_valid_q <= retire;
      if (retire) begin
        out_result_q <= alu;
        out_idx_q    <= head;
        head         <= head + IDX_W'(1);
      end
      if (alloc) tail <= tail + IDX_W'(1);
      case ({alloc, retire})
        2'b10:   occ <= occ + (IDX_W+1)'(1);
        2'b01:   occ <= occ - (IDX_W+1)'(1);
        default: occ <= occ;
      endcase
    end
  end

  // Payload needs no reset: it is only observed through a valid entry.
  always_ff @(posedge clk) begin
    if (alloc) begin
      e_op[tail] <= bus.in_opcode;
      e_a[tail]  <= bus.in_a;
      e_b[tail]  <= bus.in_b;
    end
  end
endmodule

// File: tb/tb_rs_alu_lane.sv
// tb/tb_rs_alu_lane.sv - directed self-checking bench for rs_alu_lane
module tb_rs_alu_lane;
  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  rs_alu_lane_if #(.DATA_W(8), .RS_DEPTH(4)) bus ();

  rs_alu_lane #(.DATA_W(8), .RS_DEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic alloc(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    bus.in_valid  = 1'b1;
    bus.in_opcode = op;
    bus.in_a      = a;
    bus.in_b      = b;
    tick();
    bus.in_valid  = 1'b0;
  endtask

  task automatic mark(input logic [1:0] idx);
    bus.mark_valid = 1'b1;
    bus.mark_idx   = idx;
    tick();
    bus.mark_valid = 1'b0;
  endtask

  task automatic do_flush();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
  endtask

  initial begin
    reset          = 1'b1;
    bus.in_valid   = 1'b0;
    bus.in_opcode  = 3'd0;
    bus.in_a       = 8'd0;
    bus.in_b       = 8'd0;
    bus.mark_valid = 1'b0;
    bus.mark_idx   = 2'd0;
    bus.flush      = 1'b0;
    #12 reset = 1'b0;
    #1;
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_empty", bus.empty, 1);
    check("rst_full", bus.full, 0);
    check("rst_in_idx", bus.in_idx, 0);
    check("rst_occ", bus.occupancy, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_result", bus.out_result, 0);

    // ADD 200+100 with carry
    bus.in_valid = 1'b1; bus.in_opcode = 3'd0; bus.in_a = 8'd200; bus.in_b = 8'd100;
    check("t1_in_idx", bus.in_idx, 0);
    tick();
    bus.in_valid = 1'b0;
    check("t1_occ", bus.occupancy, 1);
    check("t1_empty", bus.empty, 0);
    mark(2'd0);
    check("t1_no_bypass", bus.out_valid, 0);
    tick();
    check("t1_ov", bus.out_valid, 1);
    check("t1_res", bus.out_result, 9'h12C);
    check("t1_idx", bus.out_idx, 0);
    check("t1_empty2", bus.empty, 1);
    tick();
    check("t1_pulse", bus.out_valid, 0);
    check("t1_hold", bus.out_result, 9'h12C);

    // in-order retire of SUB / SLL / LTU
    do_flush();
    check("t2_in_idx", bus.in_idx, 0);
    alloc(3'd1, 8'd5, 8'd10);
    alloc(3'd5, 8'h81, 8'd9);
    alloc(3'd7, 8'd3, 8'd7);
    mark(2'd2);
    check("t2_m2", bus.out_valid, 0);
    mark(2'd1);
    check("t2_m1", bus.out_valid, 0);
    mark(2'd0);
    check("t2_m0", bus.out_valid, 0);
    tick();
    check("t2_ov0", bus.out_valid, 1);
    check("t2_idx0", bus.out_idx, 0);
    check("t2_sub", bus.out_result, 9'h1FB);
    tick();
    check("t2_ov1", bus.out_valid, 1);
    check("t2_idx1", bus.out_idx, 1);
    check("t2_sll", bus.out_result, 9'h002);
    tick();
    check("t2_ov2", bus.out_valid, 1);
    check("t2_idx2", bus.out_idx, 2);
    check("t2_ltu", bus.out_result, 9'h001);
    tick();
    check("t2_end_ov", bus.out_valid, 0);
    check("t2_end_empty", bus.empty, 1);

    // full, ignored offer, no full bypass, wrap
    do_flush();
    for (int i = 0; i < 4; i++) alloc(3'd0, 8'(10 + i), 8'd1);
    check("t3_full", bus.full, 1);
    check("t3_in_ready", bus.in_ready, 0);
    check("t3_occ", bus.occupancy, 4);
    check("t3_in_idx", bus.in_idx, 0);
    bus.in_valid = 1'b1; bus.in_opcode = 3'd0; bus.in_a = 8'd99; bus.in_b = 8'd0;
    tick();
    check("t3_5th_ignored", bus.occupancy, 4);
    mark(2'd0);
    check("t3_mark_occ", bus.occupancy, 4);
    tick();
    check("t3_ret_ov", bus.out_valid, 1);
    check("t3_ret_res", bus.out_result, 9'd11);
    check("t3_ret_idx", bus.out_idx, 0);
    check("t3_no_bypass_occ", bus.occupancy, 3);
    check("t3_ready_after", bus.in_ready, 1);
    check("t3_wrap_idx", bus.in_idx, 0);
    tick();
    bus.in_valid = 1'b0;
    check("t3_refill_occ", bus.occupancy, 4);
    check("t3_refill_full", bus.full, 1);

    // mark on invalid slot, head blocking, same-cycle mark+alloc
    do_flush();
    mark(2'd3);
    check("t4_empty_mark_occ", bus.occupancy, 0);
    for (int i = 0; i < 3; i++) alloc(3'd0, 8'd1, 8'd1);
    alloc(3'd4, 8'hF0, 8'h0F);
    mark(2'd0);
    check("t4_m0", bus.out_valid, 0);
    mark(2'd1);
    check("t4_r0", bus.out_idx, 0);
    mark(2'd2);
    check("t4_r1", bus.out_idx, 1);
    tick();
    check("t4_r2", bus.out_idx, 2);
    tick();
    tick();
    check("t4_idx3_not_ready", bus.out_valid, 0);
    check("t4_occ1", bus.occupancy, 1);
    mark(2'd3);
    tick();
    check("t4_ov3", bus.out_valid, 1);
    check("t4_idx3", bus.out_idx, 3);
    check("t4_xor", bus.out_result, 9'h0FF);
    bus.in_valid = 1'b1; bus.in_opcode = 3'd0; bus.in_a = 8'd1; bus.in_b = 8'd1;
    bus.mark_valid = 1'b1; bus.mark_idx = 2'd0;
    tick();
    bus.in_valid = 1'b0; bus.mark_valid = 1'b0;
    tick();
    tick();
    check("t4_same_cycle_mark", bus.out_valid, 0);
    check("t4_same_cycle_occ", bus.occupancy, 1);
    mark(2'd0);
    tick();
    check("t4_late_res", bus.out_result, 9'd2);

    // flush beats same-cycle allocate and mark
    do_flush();
    alloc(3'd2, 8'h0F, 8'h30);
    alloc(3'd3, 8'hF0, 8'h3C);
    alloc(3'd6, 8'h80, 8'd11);
    mark(2'd1);
    check("t5_pre_ov", bus.out_valid, 0);
    bus.flush = 1'b1; bus.in_valid = 1'b1; bus.mark_valid = 1'b1; bus.mark_idx = 2'd0;
    tick();
    bus.flush = 1'b0; bus.in_valid = 1'b0; bus.mark_valid = 1'b0;
    check("t5_occ", bus.occupancy, 0);
    check("t5_in_idx", bus.in_idx, 0);
    check("t5_ov", bus.out_valid, 0);
    check("t5_empty", bus.empty, 1);
    check("t5_hold", bus.out_result, 9'd2);
    tick();
    check("t5_ov2", bus.out_valid, 0);
    alloc(3'd2, 8'h0F, 8'h30);
    alloc(3'd3, 8'hF0, 8'h3C);
    mark(2'd0);
    tick();
    check("t5_or", bus.out_result, 9'h03F);
    tick();
    check("t5_ready_cleared", bus.out_valid, 0);
    check("t5_occ1", bus.occupancy, 1);
    do_flush();
    alloc(3'd6, 8'h80, 8'd11);
    mark(2'd0);
    tick();
    check("t5_srl", bus.out_result, 9'h010);

    // async reset while a result is valid
    do_flush();
    alloc(3'd0, 8'd200, 8'd100);
    mark(2'd0);
    tick();
    check("t6_pre_ov", bus.out_valid, 1);
    #2 reset = 1'b1;
    #1;
    check("t6_ov", bus.out_valid, 0);
    check("t6_res", bus.out_result, 0);
    check("t6_empty", bus.empty, 1);
    check("t6_in_ready", bus.in_ready, 1);
    #3 reset = 1'b0;
    tick();
    check("t6_after_ov", bus.out_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rs_alu_lane.md
Name: rs_alu_lane

Overview:
Parametrised single SIMD lane with a circular reservation station (RS) feeding an in-order ALU. Instructions are allocated at the RS tail under valid/ready backpressure. Each allocated slot is marked ready later by slot index. The head entry executes once it is ready and produces a registered, tagged result. Successor to the fixed 8-bit/4-entry lane: adds width/depth parameters, full/empty/occupancy, backpressure, flush, result-valid and tag, and shift/compare opcodes.

Parameters:
DATA_W, 8, operand width in bits; result is DATA_W+1 bits.
RS_DEPTH, 4, number of RS entries; power of two, minimum 2.
IDX_W, $clog2(RS_DEPTH), slot index width; derived, not overridden.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
in_valid  input  1  instruction offered
in_ready  output  1  RS can accept an instruction (= !full)
in_opcode  input  3  operation select
in_a  input  DATA_W  operand A
in_b  input  DATA_W  operand B
in_idx  output  IDX_W  slot the offered instruction will occupy (= tail pointer, combinational)
mark_valid  input  1  mark-ready strobe
mark_idx  input  IDX_W  slot to mark ready
flush  input  1  synchronous clear of all RS entries
out_valid  output  1  result valid, one-cycle pulse per retired entry
out_result  output  DATA_W+1  result
out_idx  output  IDX_W  slot index the result came from
occupancy  output  IDX_W+1  number of valid entries
full  output  1  occupancy == RS_DEPTH
empty  output  1  occupancy == 0

Behaviour:
- Reset (async): all entry valid/ready bits = 0; head = tail = 0; occupancy = 0; out_valid = 0; out_result = 0; out_idx = 0. Outputs therefore read: in_ready = 1, empty = 1, full = 0, in_idx = 0.
- Allocate: an instruction is accepted when in_valid && in_ready at a clock edge.
  - The tail entry stores opcode, A and B, with valid = 1 and ready = 0.
  - tail advances by 1 modulo RS_DEPTH (wraps to 0).
  - Without in_ready, the offer is ignored and no state changes.
- Mark: at an edge with mark_valid, entry[mark_idx].ready is set to 1, but only if that entry is valid. A mark on an invalid slot is ignored. Marking an already-ready entry has no effect.
- Mark and allocate in the same cycle are independent, except when mark_idx equals the slot being allocated: the slot was invalid before the edge, so the mark is ignored and the new entry lands with ready = 0.
- Execute/retire (in order): at an edge where entry[head] is valid and ready:
  - out_result is computed from the head entry.
  - out_idx = head and out_valid = 1.
  - entry[head].valid and ready are cleared.
  - head advances by 1 modulo RS_DEPTH.
  - Otherwise out_valid = 0 and out_result/out_idx hold their last values.
  - Younger ready entries never bypass a non-ready head.
- Latency: mark sampled at edge N → the earliest retire is at edge N+1 (ready is registered; no same-edge bypass). Back-to-back ready entries retire on consecutive cycles.
- Occupancy per edge: +1 on allocate, -1 on retire, unchanged when both happen. full and empty are decoded from the registered occupancy.
- No full bypass: when full, in_ready = 0 even if a retire happens in the same cycle. in_ready rises the cycle after the retire.
- Opcodes (A, B unsigned, result DATA_W+1 bits):
  - 000 ADD: A+B, bit DATA_W = carry.
  - 001 SUB: A-B modulo 2^(DATA_W+1) (5-10 gives 0x1FB when DATA_W = 8).
  - 010 OR, 011 AND, 100 XOR: zero-extended.
  - 101 SLL: A << (B mod DATA_W), truncated to DATA_W bits, zero-extended.
  - 110 SRL: A >> (B mod DATA_W), zero-extended.
  - 111 LTU: 1 if A < B else 0.
- Flush: synchronous, with highest priority.
  - All valid/ready bits are cleared, head = tail = 0, occupancy = 0, out_valid = 0 next cycle; out_result/out_idx hold.
  - A same-cycle allocate, mark or retire is discarded.
- Reset asserted mid-operation: immediately returns all state to reset values, regardless of clk.

Test Plan:
- Reset, then allocate ADD A=200 B=100 (in_idx = 0); mark idx 0 on the next edge → one cycle later out_valid = 1, out_result = 0x12C, out_idx = 0; then empty = 1.
- Allocate SUB 5,10, SLL 0x81,9, LTU 3,7 into idx 0,1,2; mark 2 then 1 (no output); mark 0 → out_valid on 3 consecutive cycles with out_idx 0,1,2 and results 0x1FB, 0x002, 0x001.
- Allocate 4 entries → full = 1, in_ready = 0, occupancy = 4; a 5th offer is ignored. Mark idx 0 → retire; in_ready = 1 one cycle after the retire. Allocate → in_idx = 0 (wrap); occupancy = 4.
- Mark idx 3 while empty → ignored. Later allocate into idx 3 → its ready bit is still 0, and no retire occurs without a new mark.
- 3 entries held, 1 marked; assert flush together with in_valid → occupancy = 0, in_idx = 0, out_valid stays 0, new instruction not stored.
- Assert reset asynchronously between edges while out_valid = 1 → out_valid = 0, out_result = 0, empty = 1 immediately.
